// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed N-digit 7-segment driver with frame snapshot and 4-bit PWM brightness
// Ports: CLK, RST (async, active high), D packed hex nibbles (digit 0 rightmost), DP decimal points,
//        BRIGHT 0..15, DIGIT one-hot enables, SEG {dp,g,f,e,d,c,b,a}, FRAME one-cycle snapshot pulse.
// Optional: define DISPLAY_LZB_EN for leading-zero blanking of digits above digit 0.
module display_scan_mux #(
  parameter int DIGITS           = 4,
  parameter int SCAN_W           = 16,
  parameter int DIGIT_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [4*DIGITS-1:0] D,
  input  logic [DIGITS-1:0]   DP,
  input  logic [3:0]          BRIGHT,
  output logic [DIGITS-1:0]   DIGIT,
  output logic [7:0]          SEG,
  output logic                FRAME
);
  localparam int IW = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIGIT_ACTIVE_LOW != 0}};
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};
  logic [SCAN_W-1:0]   r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_d;
  logic [DIGITS-1:0]   r_dp;
  logic [3:0]          r_br;
  logic                r_frame;
  logic [DIGITS-1:0]   r_digit;
  logic [7:0]          r_seg;
  logic [3:0]          w_nib;
  logic [6:0]          w_hex;
  logic                w_on;
  logic                w_snap;
  logic [DIGITS-1:0]   w_oh;
  logic [DIGITS-1:0]   w_blank;
  logic [7:0]          w_seg;
  always_comb begin
    w_nib = r_d[{r_idx, 2'b00} +: 4];
    case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      default: w_hex = 7'h71;
    endcase
    // top nibble 15 never satisfies the compare, which guarantees the dark gap before each idx change
    w_on = r_cnt[SCAN_W-1 -: 4] < r_br;
    w_snap = r_cnt == '0 && r_idx == '0;
    w_oh = DIGITS'(1) << r_idx;
    w_seg = {r_dp[r_idx], w_blank[r_idx] ? 7'h00 : w_hex};
  end
`ifdef DISPLAY_LZB_EN
  // digit k is blanked when it and every more significant digit are zero; digit 0 never blanks
  always_comb begin
    logic z;
    z = 1'b1;
    w_blank = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      z = z && r_d[4*k +: 4] == 4'h0;
      w_blank[k] = z;
    end
  end
`else
  assign w_blank = '0;
`endif
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_d     <= '0;
      r_dp    <= '0;
      r_br    <= '0;
      r_frame <= 1'b0;
      r_digit <= DIG_OFF;
      r_seg   <= SEG_OFF;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      if (&r_cnt) r_idx <= r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1;
      r_frame <= w_snap;
      if (w_snap) begin
        r_d  <= D;
        r_dp <= DP;
        r_br <= BRIGHT;
      end
      r_digit <= w_on ? w_oh ^ DIG_OFF : DIG_OFF;
      r_seg   <= w_on ? w_seg ^ SEG_OFF : SEG_OFF;
    end
  end
  assign DIGIT = r_digit;
  assign SEG   = r_seg;
  assign FRAME = r_frame;
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: table vectors, corner sequences and randomized run against an edge-count model
module tb_display_scan_mux;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] D = '0;
  logic [3:0]  DP = '0;
  logic [3:0]  BRIGHT = '0;
  logic [3:0]  DIGIT;
  logic [7:0]  SEG;
  logic        FRAME;
  int vec = 0;
  int bad = 0;
  int ecnt = 0;
  logic ck_en = 1'b0;

  display_scan_mux #(.DIGITS(4), .SCAN_W(6), .DIGIT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
    .CLK(CLK), .RST(RST), .D(D), .DP(DP), .BRIGHT(BRIGHT),
    .DIGIT(DIGIT), .SEG(SEG), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the n-th edge after reset sees slot position n mod 64, digit (n/64) mod 4,
  // frame start when n mod 256 == 0; outputs reflect the snapshot held before that edge.
  logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          n;
  logic [15:0] s_d;
  logic [3:0]  s_dp, s_br, e_dig;
  logic [7:0]  e_seg;
  logic        e_frm;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      n = 0; s_d = '0; s_dp = '0; s_br = '0;
      e_dig = 4'hF; e_seg = 8'hFF; e_frm = 1'b0;
    end else begin
      int c, k;
      logic on, blank;
      logic [3:0] nib;
      c = n % 64;
      k = (n / 64) % 4;
      on = (c / 4) < s_br;
      nib = 4'((s_d >> (4 * k)) & 16'hF);
      blank = 1'b0;
`ifdef DISPLAY_LZB_EN
      blank = k > 0 && (s_d >> (4 * k)) == 16'h0;
`endif
      e_dig = on ? ~(4'b1 << k) : 4'hF;
      e_seg = on ? ~{s_dp[k], blank ? 7'h00 : hex[nib]} : 8'hFF;
      e_frm = n % 256 == 0;
      if (e_frm) begin
        s_d = D; s_dp = DP; s_br = BRIGHT;
      end
      n++;
    end
  end

  always @(negedge CLK) if (ck_en) begin
    chk("model_digit", DIGIT, e_dig);
    chk("model_seg", SEG, e_seg);
    chk("model_frame", FRAME, e_frm);
    chk("onehot", $countones(~DIGIT) <= 1, 1);
  end

  task automatic reset_run();
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    #2 RST = 1'b0;
    ecnt = 0;
  endtask

  task automatic step_to(input int t);
    while (ecnt < t) begin
      @(posedge CLK);
      ecnt++;
    end
    #1;
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  br;
    int          edge_n;
    logic [3:0]  dig;
    logic [7:0]  seg;
  } vec_t;
  vec_t tv[$];

  initial begin
    int cnt[4];
    int p;
    logic lzb;
    lzb = 1'b0;
`ifdef DISPLAY_LZB_EN
    lzb = 1'b1;
`endif
    tv.push_back('{16'h1234, 4'h0, 4'hF,   3, 4'hE, 8'h99});
    tv.push_back('{16'h1234, 4'h0, 4'hF,  67, 4'hD, 8'hB0});
    tv.push_back('{16'h1234, 4'h0, 4'hF, 131, 4'hB, 8'hA4});
    tv.push_back('{16'h1234, 4'h0, 4'hF, 195, 4'h7, 8'hF9});
    tv.push_back('{16'h1234, 4'h0, 4'hF,  60, 4'hE, 8'h99});
    tv.push_back('{16'h1234, 4'h0, 4'hF,  61, 4'hF, 8'hFF});
    tv.push_back('{16'h1234, 4'h0, 4'h0,  67, 4'hF, 8'hFF});
    tv.push_back('{16'h0050, 4'h4, 4'hF,   3, 4'hE, 8'hC0});
    tv.push_back('{16'h0050, 4'h4, 4'hF,  67, 4'hD, 8'h92});
    tv.push_back('{16'h0050, 4'h4, 4'hF, 131, 4'hB, lzb ? 8'h7F : 8'h40});
    tv.push_back('{16'h0050, 4'h4, 4'hF, 195, 4'h7, lzb ? 8'hFF : 8'hC0});
    tv.push_back('{16'hABCD, 4'hF, 4'h8,   3, 4'hE, 8'h21});
    tv.push_back('{16'hABCD, 4'hF, 4'h8,  35, 4'hF, 8'hFF});
    tv.push_back('{16'hABCD, 4'hF, 4'h8, 195, 4'h7, 8'h08});

    #3 RST = 1'b1;
    #1;
    chk("rst_digit", DIGIT, 4'hF);
    chk("rst_seg", SEG, 8'hFF);
    chk("rst_frame", FRAME, 1'b0);
    ck_en = 1'b1;

    foreach (tv[i]) begin
      D = tv[i].d; DP = tv[i].dp; BRIGHT = tv[i].br;
      reset_run();
      step_to(tv[i].edge_n);
      chk("tbl_digit", DIGIT, tv[i].dig);
      chk("tbl_seg", SEG, tv[i].seg);
    end

    // FRAME: pulses right after the first edge, then every 256 clocks
    D = 16'h1234; DP = 4'h0; BRIGHT = 4'hF;
    reset_run();
    step_to(1);
    chk("frame_first", FRAME, 1'b1);
    p = 1;
    while (p < 400) begin
      step_to(ecnt + 1);
      if (FRAME) break;
      p++;
    end
    chk("frame_period", p, 256);
    step_to(ecnt + 1);
    chk("frame_width", FRAME, 1'b0);

    // PWM duty over one full steady frame
    BRIGHT = 4'h4;
    reset_run();
    step_to(256);
    cnt = '{0, 0, 0, 0};
    for (int e = 0; e < 256; e++) begin
      step_to(ecnt + 1);
      for (int k = 0; k < 4; k++) if (DIGIT == ~(4'b1 << k)) cnt[k]++;
    end
    for (int k = 0; k < 4; k++) chk("pwm4_lit", cnt[k], 16);
    BRIGHT = 4'h0;
    reset_run();
    step_to(256);
    p = 0;
    for (int e = 0; e < 256; e++) begin
      step_to(ecnt + 1);
      if (DIGIT != 4'hF) p++;
    end
    chk("pwm0_lit", p, 0);

    // Snapshot: mid-frame change invisible until next frame
    D = 16'h1234; BRIGHT = 4'hF;
    reset_run();
    step_to(74);
    @(negedge CLK);
    D = 16'h5678;
    step_to(131);
    chk("snap_old_digit", DIGIT, 4'hB);
    chk("snap_old_seg", SEG, 8'hA4);
    step_to(259);
    chk("snap_new_digit", DIGIT, 4'hE);
    chk("snap_new_seg", SEG, 8'h80);

    // Async reset mid slot 2
    D = 16'h1234;
    reset_run();
    step_to(148);
    chk("pre_arst_digit", DIGIT, 4'hB);
    #2 RST = 1'b1;
    #1;
    chk("arst_digit", DIGIT, 4'hF);
    chk("arst_seg", SEG, 8'hFF);
    chk("arst_frame", FRAME, 1'b0);
    @(negedge CLK);
    #2 RST = 1'b0;
    ecnt = 0;
    step_to(3);
    chk("arst_resume_digit", DIGIT, 4'hE);
    chk("arst_resume_seg", SEG, 8'h99);

    // Randomized run checked continuously against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < 4; k++) D[4*k +: 4] = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
        DP = 4'($urandom);
        BRIGHT = 4'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 RST = 1'b1;
        @(negedge CLK);
        #2 RST = 1'b0;
      end
    end
    @(negedge CLK);
    ck_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
